// File: rtl/rr_arb8_if.sv
// Request/grant bundle between the requesters (master side) and the
// round-robin arbiter (slave side).
interface rr_arb8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arb8.sv
// rr_arb8: 8-way round-robin arbiter with a bounded hold time.
// A grant is issued from IDLE only, so every release is followed by at
// least one cycle with no grant. The priority pointer moves one past the
// last holder on release, which gives fair rotation among active requesters.
// The timeout output pulses for one cycle when a grant is forcibly ended
// because it reached MAX_HOLD cycles while the holder still wanted it.
module rr_arb8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  rr_arb8_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  // Counter value seen at the edge that ends the MAX_HOLD-th visible cycle.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_ptr;
  logic [2:0]       w_ptr_nxt;
  logic [CNT_W-1:0] r_hold;
  logic [CNT_W-1:0] w_hold_nxt;
  logic [7:0]       r_gnt;
  logic [7:0]       w_gnt_nxt;
  logic [2:0]       r_gnt_id;
  logic [2:0]       w_gnt_id_nxt;
  logic             r_gnt_valid;
  logic             w_gnt_valid_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;

  logic [2:0]       w_pick;
  logic             w_any_req;
  logic             w_expired;
  logic             w_dropped;

  // First set request bit at or after ptr, wrapping modulo 8.
  // Scanning from the far end lets the nearest hit overwrite earlier ones.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr);
    logic [2:0] idx;
    rr_pick = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  assign w_pick    = rr_pick(bus.req, r_ptr);
  assign w_any_req = |bus.req;
  assign w_expired = (r_hold == HOLD_LAST);
  assign w_dropped = ~bus.req[r_gnt_id];

  // Next-state and next-output decode for the IDLE/BUSY controller.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_hold_nxt      = r_hold;
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_gnt_valid_nxt = r_gnt_valid;
    w_timeout_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt     = BUSY;
          w_gnt_nxt       = 8'b1 << w_pick;
          w_gnt_id_nxt    = w_pick;
          w_gnt_valid_nxt = 1'b1;
          w_hold_nxt      = '0;
        end else begin
          w_gnt_nxt       = 8'h00;
          w_gnt_id_nxt    = 3'd0;
          w_gnt_valid_nxt = 1'b0;
        end
      end
      BUSY: begin
        if (bus.done || w_dropped || w_expired) begin
          w_state_nxt     = IDLE;
          w_gnt_nxt       = 8'h00;
          w_gnt_id_nxt    = 3'd0;
          w_gnt_valid_nxt = 1'b0;
          w_ptr_nxt       = r_gnt_id + 3'd1;
          // Only a release caused purely by the hold limit counts as forced.
          w_timeout_nxt   = w_expired && !bus.done && !w_dropped;
        end else begin
          // Release always happens at HOLD_LAST, so this never wraps.
          w_hold_nxt      = r_hold + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= 3'd0;
      r_hold      <= '0;
      r_gnt       <= 8'h00;
      r_gnt_id    <= 3'd0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_hold      <= w_hold_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.timeout   = r_timeout;

endmodule

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum consecutive cycles one grant may be held (legal range 2..255).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  8  request vector; bit i = requester i wants the shared resource.
REQ-006 done  input  1  current grant holder releases the resource; sampled only while a grant is active.
REQ-007 gnt  output  8  one-hot grant vector; all zero when no grant.
REQ-008 gnt_id  output  3  binary index of granted requester; 0 when gnt_valid=0.
REQ-009 gnt_valid  output  1  high when exactly one gnt bit is set.
REQ-010 timeout  output  1  single-cycle pulse marking a forced release.

Function
REQ-011 The FSM SHALL have two states: IDLE (no grant) and BUSY (grant held). All outputs SHALL be registered.
REQ-012 The arbiter SHALL hold a 3-bit priority pointer ptr. The search order SHALL be ptr, ptr+1, ... 7, 0, ... ptr-1, with wrap modulo 8.
REQ-013 IDLE, any req bit set at a rising edge: in the same edge, select the first set bit in search order, load gnt/gnt_id, set gnt_valid, and enter BUSY. Grant latency is one cycle from req sampled.
REQ-014 IDLE, req=0: remain in IDLE with all outputs 0.
REQ-015 BUSY: gnt, gnt_id and gnt_valid SHALL remain stable. Changes on other req bits are ignored.
REQ-016 BUSY, hold counter: cleared on grant entry and incremented each BUSY cycle. Width is ceil(log2(MAX_HOLD+1)) bits. It SHALL never wrap.
REQ-017 BUSY release conditions, evaluated at each edge:
- done=1,
- req[gnt_id]=0,
- the grant has been visible for MAX_HOLD cycles.
On any release: clear gnt, gnt_id and gnt_valid, set ptr=gnt_id+1 (7 wraps to 0), and enter IDLE.
REQ-018 Forced release (MAX_HOLD reached with done=0 and req[gnt_id]=1) SHALL assert timeout for exactly the first IDLE cycle. timeout is 0 otherwise.
REQ-019 Simultaneous done=1 and MAX_HOLD reached: treat as a normal release, with timeout=0.
REQ-020 After any release there SHALL be at least one IDLE cycle with gnt=0 before the next grant. A grant is never handed directly from one requester to another.
REQ-021 A requester that keeps req high after release SHALL be granted again only after every other active requester in search order.
REQ-022 gnt SHALL be one-hot or zero in every cycle. gnt_valid SHALL equal the OR of gnt.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for a clock edge, force gnt=0, gnt_id=0, gnt_valid=0, timeout=0, state=IDLE, ptr=0 and hold counter=0.
REQ-024 Reset asserted mid-grant SHALL drop the grant and leave no pending release or timeout after deassertion. The first grant after reset favours requester 0.

Verification
REQ-025 Reset release, req=8'b10000001: gnt=8'h01, gnt_id=0 one cycle later. Pulse done, then one gnt=0 cycle, then gnt=8'h80, gnt_id=7.
REQ-026 req=8'hFF held, done pulsed on each grant's second cycle: gnt_id sequence is 0,1,2,...,7,0, with one idle cycle between grants.
REQ-027 req=8'h04 held, done=0, MAX_HOLD=16: gnt=8'h04 for exactly 16 cycles, then gnt=0 with timeout=1 for one cycle, then gnt=8'h04 again (wrap search from ptr=3).
REQ-028 Same as REQ-027 but done=1 on the 16th grant cycle: release occurs with timeout=0.
REQ-029 Granted requester drops its req bit mid-grant: gnt=0 next cycle and ptr advances. Requester 5 drops while holding: the next grant goes to the first set bit from 6.
REQ-030 rst_n pulsed low while gnt=8'h10: gnt=0 and gnt_valid=0 asynchronously. After release with req=8'hFF, the first grant is gnt_id=0.
